// File: rtl/brisc_dbg_pkg.sv
// brisc_dbg_pkg: definitions shared by the register file, the register dump
// engine and the debug serializer.
package brisc_dbg_pkg;

  // Register file geometry, shared by every block that touches the regfile.
  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 16;

  // Dump engine states. DUMP_CHK is only reachable when the checksum word is
  // compiled in.
  typedef enum logic [1:0] {
    DUMP_IDLE    = 2'd0,
    DUMP_SETTLE  = 2'd1,
    DUMP_PRESENT = 2'd2,
    DUMP_CHK     = 2'd3
  } dump_state_e;

endpackage : brisc_dbg_pkg

// File: rtl/regfile_dump.sv
// regfile_dump: walks a wrapping range of the register file through a spare
// read port and streams each value out over valid/ready. Each address is held
// for SETTLE_CYCLES before capture so that either phase of the register
// file's read/write alternation has produced stable data.
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append a trailing word
// holding the XOR of all emitted register words (out_last moves to it).
module regfile_dump
  import brisc_dbg_pkg::*;
#(
  parameter int NUM_REGS      = 16,
  parameter int ADDR_W        = REG_ADDR_W,
  parameter int DATA_W        = REG_DATA_W,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  MAX_COUNT   = CNT_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d, out_last_d, done_d;
  logic              handshake;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;
`endif

  assign handshake = out_valid & out_ready;
  assign busy      = (state_q != DUMP_IDLE);

  // Next-state and next-output logic for the dump sequencer.
  always_comb begin
    // NOTE: every signal gets a default here first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    rd_addr_d   = rd_addr;
    remaining_d = remaining_q;
    settle_d    = settle_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    done_d      = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    chk_d       = chk_q;
`endif

    case (state_q)
      DUMP_IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            rd_addr_d   = base_addr;
            remaining_d = (count > MAX_COUNT) ? MAX_COUNT : count;
            settle_d    = SETTLE_LOAD;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            chk_d       = '0;
`endif
            state_d     = DUMP_SETTLE;
          end
        end
      end

      DUMP_SETTLE: begin
        if (settle_q == '0) begin
          out_data_d  = rd_data;
          out_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          out_last_d  = 1'b0;
          chk_d       = chk_q ^ rd_data;
`else
          out_last_d  = (remaining_q == CNT_W'(1));
`endif
          state_d     = DUMP_PRESENT;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      DUMP_PRESENT: begin
        if (handshake) begin
          if (remaining_q > CNT_W'(1)) begin
            rd_addr_d   = (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
            remaining_d = remaining_q - CNT_W'(1);
            settle_d    = SETTLE_LOAD;
            out_valid_d = 1'b0;
            state_d     = DUMP_SETTLE;
          end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            // Present the checksum straight away; chk_q already includes
            // the word just accepted.
            out_data_d  = chk_q;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            state_d     = DUMP_CHK;
`else
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = DUMP_IDLE;
`endif
          end
        end
      end

`ifdef REGFILE_DUMP_CHECKSUM_EN
      DUMP_CHK: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = DUMP_IDLE;
        end
      end
`endif

      default: state_d = DUMP_IDLE;
    endcase

    // Abort overrides everything, including a start seen in IDLE; the read
    // address is left where it was.
    if (abort) begin
      state_d     = DUMP_IDLE;
      rd_addr_d   = rd_addr;
      out_data_d  = out_data;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      done_d      = 1'b0;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= DUMP_IDLE;
      rd_addr     <= '0;
      remaining_q <= '0;
      settle_q    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      done        <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q     <= state_d;
      rd_addr     <= rd_addr_d;
      remaining_q <= remaining_d;
      settle_q    <= settle_d;
      out_data    <= out_data_d;
      out_valid   <= out_valid_d;
      out_last    <= out_last_d;
      done        <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

endmodule : regfile_dump

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed self-checking bench for regfile_dump. A small
// register-file model answers the read port one cycle after the address.
module tb_regfile_dump;
  import brisc_dbg_pkg::*;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        CLK       = 1'b0;
  logic        RST_N     = 1'b0;
  logic        start     = 1'b0;
  logic        abort     = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  count     = '0;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data   = '0;
  logic [15:0] out_data;
  logic        out_valid, out_last, busy, done;

  logic [15:0] regs [16];
  int passes = 0;
  int total  = 0;

  regfile_dump dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .count     (count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  // Register file model: synchronous read port.
  always @(posedge CLK) rd_data <= regs[rd_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Wait (bounded) for out_valid, then check the presented word and, when
  // exp_wait >= 0, how many cycles it took to appear.
  task automatic expect_word(input string tag, input logic [15:0] d, input logic l,
                             input int exp_wait);
    int w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      step(1);
      w++;
    end
    check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " data"}, {16'd0, out_data}, {16'd0, d});
    check({tag, " last"}, {31'd0, out_last}, {31'd0, l});
    if (exp_wait >= 0) check({tag, " wait"}, w, exp_wait);
  endtask

  // Full dump with out_ready held high; expected words from the regs model.
  task automatic dump_seq(input string tag, input logic [3:0] base, input logic [4:0] cnt);
    int n;
    logic [15:0] x;
    logic [3:0]  a;
    n = (cnt > 5'd16) ? 16 : int'(cnt);
    x = '0;
    a = base;
    base_addr = base;
    count     = cnt;
    out_ready = 1'b1;
    start     = 1'b1;
    step(1);
    start = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    check({tag, " rd_addr"}, {28'd0, rd_addr}, {28'd0, base});
    for (int i = 0; i < n; i++) begin
      expect_word($sformatf("%s w%0d", tag, i), regs[a], (i == n - 1) && !CK, 3);
      x = x ^ regs[a];
      a = a + 4'd1;
      step(1);
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    expect_word({tag, " chk"}, x, 1'b1, 0);
    step(1);
`endif
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy end"}, {31'd0, busy}, 32'd0);
    check({tag, " valid end"}, {31'd0, out_valid}, 32'd0);
    step(1);
    check({tag, " done once"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);

    // Reset state.
    step(2);
    check("rst rd_addr", {28'd0, rd_addr}, 32'd0);
    check("rst out_data", {16'd0, out_data}, 32'd0);
    check("rst valid", {31'd0, out_valid}, 32'd0);
    check("rst last", {31'd0, out_last}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    RST_N = 1'b1;
    step(1);

    // Full range, wrap-around, and clamped count (17 -> 16, starting at 8).
    dump_seq("full", 4'd0, 5'd16);
    dump_seq("wrap", 4'd14, 5'd4);
    dump_seq("clamp", 4'd8, 5'd17);

    // Back-pressure: out_ready low for 10 cycles on the first word.
    base_addr = 4'd3;
    count     = 5'd2;
    out_ready = 1'b0;
    start     = 1'b1;
    step(1);
    start = 1'b0;
    expect_word("stall w0", 16'h1003, 1'b0, 3);
    for (int k = 0; k < 10; k++) begin
      step(1);
      check($sformatf("stall hold%0d valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("stall hold%0d data", k), {16'd0, out_data}, 32'h1003);
    end
    out_ready = 1'b1;
    step(1);
    expect_word("stall w1", 16'h1004, !CK, 3);
    step(1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    expect_word("stall chk", 16'h0007, 1'b1, 0);
    step(1);
`endif
    check("stall done", {31'd0, done}, 32'd1);
    step(1);

    // count = 0: done next cycle, no word.
    base_addr = 4'd5;
    count     = 5'd0;
    start     = 1'b1;
    step(1);
    start = 1'b0;
    check("zero done", {31'd0, done}, 32'd1);
    check("zero busy", {31'd0, busy}, 32'd0);
    check("zero valid", {31'd0, out_valid}, 32'd0);
    step(1);
    check("zero done once", {31'd0, done}, 32'd0);
    check("zero valid later", {31'd0, out_valid}, 32'd0);

    // Abort while the 3rd word is presented.
    base_addr = 4'd0;
    count     = 5'd5;
    start     = 1'b1;
    step(1);
    start = 1'b0;
    expect_word("abort w0", 16'h1000, 1'b0, 3);
    step(1);
    expect_word("abort w1", 16'h1001, 1'b0, 3);
    step(1);
    expect_word("abort w2", 16'h1002, 1'b0, 3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort valid", {31'd0, out_valid}, 32'd0);
    check("abort last", {31'd0, out_last}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort rd_addr", {28'd0, rd_addr}, 32'd2);
    step(1);
    check("abort no done", {31'd0, done}, 32'd0);

    // Checksum vector: 0x00FF ^ 0x0F0F ^ 0x1234 = 0x1DC4.
    regs[0] = 16'h00FF;
    regs[1] = 16'h0F0F;
    regs[2] = 16'h1234;
    base_addr = 4'd0;
    count     = 5'd3;
    start     = 1'b1;
    step(1);
    start = 1'b0;
    expect_word("cks w0", 16'h00FF, 1'b0, 3);
    step(1);
    expect_word("cks w1", 16'h0F0F, 1'b0, 3);
    step(1);
    expect_word("cks w2", 16'h1234, !CK, 3);
    step(1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    expect_word("cks chk", 16'h1DC4, 1'b1, 0);
    step(1);
`endif
    check("cks done", {31'd0, done}, 32'd1);
    step(1);

    // Asynchronous reset in the middle of a dump.
    base_addr = 4'd5;
    count     = 5'd3;
    start     = 1'b1;
    step(1);
    start = 1'b0;
    expect_word("arst w0", 16'h1005, 1'b0, 3);
    #2 RST_N = 1'b0;
    #1;
    check("arst rd_addr", {28'd0, rd_addr}, 32'd0);
    check("arst data", {16'd0, out_data}, 32'd0);
    check("arst valid", {31'd0, out_valid}, 32'd0);
    check("arst last", {31'd0, out_last}, 32'd0);
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst done", {31'd0, done}, 32'd0);
    step(2);
    RST_N = 1'b1;
    step(2);
    check("arst idle valid", {31'd0, out_valid}, 32'd0);
    check("arst idle done", {31'd0, done}, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule : tb_regfile_dump
